// File: rtl/axis_burst_fifo.sv
// AXI-Stream FIFO that releases stored words only in bursts of BURST_LEN, or partial bursts on flush.
// Optional macro TIMEOUT_FLUSH_EN adds an idle timeout that raises an automatic flush.
module axis_burst_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   input  logic                    flush,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    burst_active
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   if (BURST_LEN < 1 || BURST_LEN > DEPTH || DEPTH < 2 || TIMEOUT < 1) begin : g_param_check
      $error("axis_burst_fifo: illegal parameter combination");
   end

   typedef enum logic {IDLE, BURST} state_e;

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [AW:0]             wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]           count_q, count_d;
   logic [CW-1:0]           beats_q, beats_d;
   logic                    flush_pending_q, flush_pending_d;
   logic                    wr_en, rd_en;
   logic                    timeout_hit;

   assign s_axis_tready = (count_q < CW'(DEPTH));
   assign m_axis_tvalid = (state_q == BURST);
   assign m_axis_tlast  = (state_q == BURST) && (beats_q == CW'(1));
   assign m_axis_tdata  = mem_q[rd_ptr_q[AW-1:0]];
   assign level         = count_q;
   assign burst_active  = (state_q == BURST);

   assign wr_en = s_axis_tvalid && s_axis_tready;
   assign rd_en = m_axis_tvalid && m_axis_tready;

   // Occupancy: simultaneous write and read cancel out.
   always_comb begin
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Burst FSM; beats never exceeds count at burst start, so a burst cannot underflow.
   always_comb begin
      state_d         = state_q;
      beats_d         = beats_q;
      flush_pending_d = flush_pending_q;
      case (state_q)
         IDLE: begin
            if (count_q >= CW'(BURST_LEN)) begin
               state_d = BURST;
               beats_d = CW'(BURST_LEN);
            end else if (flush_pending_q && (count_q != '0)) begin
               state_d = BURST;
               beats_d = count_q;
            end
            if (count_q == '0) flush_pending_d = 1'b0;
         end
         BURST: begin
            if (rd_en) begin
               beats_d = beats_q - CW'(1);
               if (beats_q == CW'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush || timeout_hit) flush_pending_d = 1'b1;
   end

`ifdef TIMEOUT_FLUSH_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] idle_cnt_q, idle_cnt_d;

   // Counts quiet cycles holding a partial burst; clears on any write, empty, or burst start.
   always_comb begin
      idle_cnt_d  = '0;
      timeout_hit = 1'b0;
      if ((state_q == IDLE) && (state_d == IDLE) && !wr_en &&
          (count_q != '0) && (count_q < CW'(BURST_LEN))) begin
         idle_cnt_d  = idle_cnt_q + TW'(1);
         timeout_hit = (idle_cnt_q == TW'(TIMEOUT - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) idle_cnt_q <= '0;
      else     idle_cnt_q <= idle_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         beats_q         <= '0;
         flush_pending_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         beats_q         <= beats_d;
         flush_pending_q <= flush_pending_d;
         if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_axis_tdata;
            wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
         end
         if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

endmodule

// File: tb/tb_axis_burst_fifo.sv
// Self-checking bench for axis_burst_fifo: directed scenarios plus randomized traffic against a queue model.
// Covers the TIMEOUT_FLUSH_EN build when the macro is defined for both files.
module tb_axis_burst_fifo;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned BL    = 4;
   localparam int unsigned TO    = 8;

   logic          clk;
   logic          rst;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          flush;
   logic [4:0]    level;
   logic          burst_active;

   axis_burst_fifo #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .flush(flush), .level(level), .burst_active(burst_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: stored words in order, words left in the current burst (0 = not bursting).
   logic [DW-1:0] mq[$];
   int            rem = 0;
   bit            pend = 1'b0;
   int            idle_cnt = 0;
   logic [DW:0]   hs_log[$];
   bit            stall_q = 1'b0;
   logic [DW-1:0] held_data;
   logic          held_last;

   always @(posedge clk) begin : model
      int sz;
      int orem;
      bit wr, rd, opend, start;
      if (!rst && m_axis_tvalid && m_axis_tready) hs_log.push_back({m_axis_tlast, m_axis_tdata});
      stall_q   = !rst && m_axis_tvalid && !m_axis_tready;
      held_data = m_axis_tdata;
      held_last = m_axis_tlast;
      if (rst) begin
         mq.delete();
         rem = 0; pend = 1'b0; idle_cnt = 0;
      end else begin
         sz = mq.size(); orem = rem; opend = pend; start = 1'b0;
         wr = s_axis_tvalid && (sz < DEPTH);
         rd = m_axis_tready && (orem > 0);
         if (orem == 0) begin
            if (sz >= BL) begin rem = BL; start = 1'b1; end
            else if (opend && sz > 0) begin rem = sz; start = 1'b1; end
         end else if (rd) rem = orem - 1;
         if (orem == 0 && sz == 0) pend = 1'b0;
         if (flush) pend = 1'b1;
`ifdef TIMEOUT_FLUSH_EN
         if (orem == 0 && !start && !wr && sz > 0 && sz < BL) begin
            idle_cnt++;
            if (idle_cnt == TO) pend = 1'b1;
         end else idle_cnt = 0;
`endif
         if (rd) void'(mq.pop_front());
         if (wr) mq.push_back(s_axis_tdata);
      end
   end

   // Every-cycle comparison of all outputs against the model, plus AXIS hold-during-stall.
   always @(negedge clk) begin
      if (check_en) begin
         chk("tready", s_axis_tready, mq.size() < DEPTH);
         chk("level", level, mq.size());
         chk("tvalid", m_axis_tvalid, rem > 0);
         chk("tlast", m_axis_tlast, rem == 1);
         chk("burst_active", burst_active, rem > 0);
         if (rem > 0) chk("tdata", m_axis_tdata, mq[0]);
         if (stall_q) begin
            chk("stall_tvalid", m_axis_tvalid, 1'b1);
            chk("stall_tdata", m_axis_tdata, held_data);
            chk("stall_tlast", m_axis_tlast, held_last);
         end
      end
   end

   task automatic wr_words(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         s_axis_tdata  = DW'(base + i);
         s_axis_tvalid = 1'b1;
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_level(input string name, input int tgt, input int bound);
      int n = 0;
      while ((int'(level) != tgt || m_axis_tvalid) && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, n < bound, 1'b1);
   endtask

   // Expected handshake log for one contiguous run of words: tlast every BL-th word and on the final one.
   task automatic chk_log(input string name, input int base, input int n);
      logic [DW:0] exp;
      chk({name, "_count"}, hs_log.size(), n);
      for (int i = 0; i < n && i < hs_log.size(); i++) begin
         exp = {((i % BL) == BL - 1) || (i == n - 1), DW'(base + i)};
         chk(name, hs_log[i], exp);
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tready", s_axis_tready, 1'b1);
      chk("rst_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_tlast", m_axis_tlast, 1'b0);
      chk("rst_level", level, 0);
      chk("rst_burst", burst_active, 1'b0);
      chk("rst_tdata", m_axis_tdata, 0);
      check_en = 1'b1;
      rst = 1'b0;

      // Full burst: tvalid appears one edge after the 4th write.
      m_axis_tready = 1'b1;
      hs_log.delete();
      wr_words(32'hDD, 4);
      chk("t1_level", level, 4);
      chk("t1_tvalid_early", m_axis_tvalid, 1'b0);
      @(negedge clk);
      chk("t1_tvalid", m_axis_tvalid, 1'b1);
      chk("t1_tdata_first", m_axis_tdata, 32'hDD);
      wait_level("t1_drain", 0, 50);
      chk_log("t1_log", 32'hDD, 4);

`ifndef TIMEOUT_FLUSH_EN
      // Partial data waits indefinitely without flush.
      hs_log.delete();
      wr_words(32'h10, 3);
      repeat (100) @(negedge clk);
      chk("t2_tvalid_held", m_axis_tvalid, 1'b0);
      chk("t2_level", level, 3);
      pulse_flush();
      wait_level("t2_drain", 0, 50);
      chk_log("t2_log", 32'h10, 3);
`endif

      // Fill to full with the sink stalled; the 17th word waits for a free slot.
      m_axis_tready = 1'b0;
      hs_log.delete();
      wr_words(0, 16);
      s_axis_tdata = 32'h10; s_axis_tvalid = 1'b1;
      chk("t3_full_tready", s_axis_tready, 1'b0);
      chk("t3_full_level", level, 16);
      repeat (3) @(negedge clk);
      chk("t3_full_hold", level, 16);
      m_axis_tready = 1'b1;
      n = 0;
      while (!s_axis_tready && n < 20) begin @(negedge clk); n++; end
      chk("t3_accept", n < 20, 1'b1);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      wait_level("t3_drain", 1, 100);
      chk_log("t3_log", 0, 16);
      chk("t3_tail_level", level, 1);
      hs_log.delete();
      pulse_flush();
      wait_level("t3_tail_drain", 0, 50);
      chk_log("t3_tail", 32'h10, 1);

      // Sink toggles ready every cycle during a burst.
      m_axis_tready = 1'b0;
      hs_log.delete();
      wr_words(32'h40, 4);
      n = 0;
      while ((level != 0 || m_axis_tvalid) && n < 40) begin
         m_axis_tready = ~m_axis_tready;
         @(negedge clk);
         n++;
      end
      chk("t4_done", n < 40, 1'b1);
      chk_log("t4_log", 32'h40, 4);

      // Reset in the middle of a burst discards everything.
      m_axis_tready = 1'b1;
      hs_log.delete();
      wr_words(32'h50, 4);
      n = 0;
      while (hs_log.size() < 2 && n < 20) begin @(negedge clk); n++; end
      chk("t5_two_beats", hs_log.size(), 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_tvalid", m_axis_tvalid, 1'b0);
      chk("t5_level", level, 0);
      chk("t5_burst", burst_active, 1'b0);
      hs_log.delete();
      wr_words(32'h60, 4);
      wait_level("t5_drain", 0, 50);
      chk_log("t5_log", 32'h60, 4);

`ifdef TIMEOUT_FLUSH_EN
      // Idle timeout: 8 quiet cycles raise the flush, burst starts one edge later.
      hs_log.delete();
      wr_words(32'h70, 2);
      n = 0;
      while (!m_axis_tvalid && n < 50) begin @(negedge clk); n++; end
      chk("t6_latency", n, TO + 1);
      wait_level("t6_drain", 0, 50);
      chk_log("t6_log", 32'h70, 2);
`endif

      // Randomized traffic with rare flushes and resets.
      for (int c = 0; c < 3000; c++) begin
         s_axis_tvalid = ($urandom_range(0, 3) != 0);
         s_axis_tdata  = $urandom;
         m_axis_tready = (c < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
         flush         = ($urandom_range(0, 63) == 0);
         rst           = ($urandom_range(0, 499) == 0);
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0; flush = 1'b0; rst = 1'b0; m_axis_tready = 1'b1;
      @(negedge clk);
      pulse_flush();
      wait_level("rand_drain", 0, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
